axis_boxcar_decimator: RTL and testbench

//  Dual-channel (X = tdata[15:0], Y = tdata[31:16]) boxcar decimator for the 14-bit RP ADC stream.
//  - Sums 2^k valid input beats per channel, emits one result per block; k is runtime programmable.
//  - Output is either the rounded average or the saturated sum.
//  - Replaces the fixed 4-tap, free-running decimator; adds true tvalid gating and a backpressured packed output.

---
 rtl/axis_boxcar_decimator.sv | 160 ++++++++++++++++
 tb/tb_axis_boxcar_decimator.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/axis_boxcar_decimator.sv
// axis_boxcar_decimator
//   Dual-channel boxcar decimator for the 14-bit ADC stream. Each block sums
//   2^k valid beats per channel. It then emits either the rounded average or
//   the sum saturated to 16 bits.
//
// Ports
//   adc_clk               clock for all logic
//   adc_resetn            synchronous active-low reset
//   dec_shift[3:0]        k, decimation N = 2^k (clamped to MAX_DEC_SHIFT)
//   dec_mode              0 = rounded average, 1 = saturated sum
//   S_AXIS_SIGNAL_tdata   [13:0] X sample, [29:16] Y sample
//   S_AXIS_SIGNAL_tvalid  input beat qualifier (always accepted)
//   M_AXIS_S0_tdata/tvalid   X result, 1-clk valid pulse
//   M_AXIS_S1_tdata/tvalid   Y result, 1-clk valid pulse
//   M_AXIS_S01_tdata/tvalid/tready  packed {Y, X}, held until accepted
//   overrun               sticky, a result replaced an unaccepted S01 word
module axis_boxcar_decimator #(
    parameter int AXIS_SIGNAL_TDATA_WIDTH            = 32,
    parameter int AXIS_SIGNAL_DATA_WIDTH             = 16,
    parameter int AXIS_SIGNAL_SIGNIFICANT_DATA_WIDTH = 14,
    parameter int MAX_DEC_SHIFT                      = 8
) (
    input  logic                               adc_clk,
    input  logic                               adc_resetn,
    input  logic [3:0]                         dec_shift,
    input  logic                               dec_mode,
    input  logic [AXIS_SIGNAL_TDATA_WIDTH-1:0] S_AXIS_SIGNAL_tdata,
    input  logic                               S_AXIS_SIGNAL_tvalid,
    output logic [AXIS_SIGNAL_DATA_WIDTH-1:0]  M_AXIS_S0_tdata,
    output logic                               M_AXIS_S0_tvalid,
    output logic [AXIS_SIGNAL_DATA_WIDTH-1:0]  M_AXIS_S1_tdata,
    output logic                               M_AXIS_S1_tvalid,
    output logic [AXIS_SIGNAL_TDATA_WIDTH-1:0] M_AXIS_S01_tdata,
    output logic                               M_AXIS_S01_tvalid,
    input  logic                               M_AXIS_S01_tready,
    output logic                               overrun
);

    localparam int DW    = AXIS_SIGNAL_DATA_WIDTH;
    localparam int TW    = AXIS_SIGNAL_TDATA_WIDTH;
    localparam int SIG_W = AXIS_SIGNAL_SIGNIFICANT_DATA_WIDTH;
    localparam int ACC_W = SIG_W + MAX_DEC_SHIFT;
    localparam int CNT_W = (MAX_DEC_SHIFT > 0) ? MAX_DEC_SHIFT : 1;

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(2 ** (DW - 1) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(2 ** (DW - 1)));

    function automatic logic [3:0] clamp_k(input logic [3:0] k);
        return (int'(k) > MAX_DEC_SHIFT) ? 4'(MAX_DEC_SHIFT) : k;
    endfunction

    // Round half toward +inf: add half an LSB of the result, then arithmetic shift.
    function automatic logic signed [DW-1:0] avg_round(input logic signed [ACC_W-1:0] s,
                                                       input logic [3:0]              k);
        logic signed [ACC_W-1:0] half;
        logic signed [ACC_W-1:0] t;
        if (k == 4'd0) begin
            t = s;
        end else begin
            half = ACC_W'(1) << (k - 4'd1);
            t    = s + half;
            t    = t >>> k;
        end
        return t[DW-1:0];
    endfunction

    function automatic logic signed [DW-1:0] sat_sum(input logic signed [ACC_W-1:0] s);
        if (s > SAT_MAX)      return SAT_MAX[DW-1:0];
        else if (s < SAT_MIN) return SAT_MIN[DW-1:0];
        else                  return s[DW-1:0];
    endfunction

    logic [CNT_W-1:0]        cnt_p0;
    logic [3:0]              k_act_p0;
    logic                    mode_act_p0;
    logic signed [ACC_W-1:0] acc_x_p0, acc_y_p0;

    logic signed [ACC_W-1:0] smp_x, smp_y, sum_x, sum_y;
    logic signed [DW-1:0]    res_x, res_y;
    logic [3:0]              k_cur;
    logic                    mode_cur, blk_start, blk_last;
    logic [CNT_W-1:0]        last_cnt;

    logic signed [DW-1:0]    res_x_p1, res_y_p1;
    logic                    vld_p1;
    logic [TW-1:0]           s01_data_p1;
    logic                    s01_vld_p1;
    logic                    ovr_p1;

    logic unused_bits;
    assign unused_bits = ^{S_AXIS_SIGNAL_tdata[DW-1:SIG_W], S_AXIS_SIGNAL_tdata[TW-1:DW+SIG_W]};

    always_comb begin
        smp_x     = {{(ACC_W-SIG_W){S_AXIS_SIGNAL_tdata[SIG_W-1]}}, S_AXIS_SIGNAL_tdata[SIG_W-1:0]};
        smp_y     = {{(ACC_W-SIG_W){S_AXIS_SIGNAL_tdata[DW+SIG_W-1]}},
                     S_AXIS_SIGNAL_tdata[DW+SIG_W-1:DW]};
        blk_start = (cnt_p0 == '0);
        // At a block start, the live config applies to the first beat, and that beat may also be the last.
        k_cur     = blk_start ? clamp_k(dec_shift) : k_act_p0;
        mode_cur  = blk_start ? dec_mode : mode_act_p0;
        last_cnt  = CNT_W'((32'd1 << k_cur) - 32'd1);
        blk_last  = S_AXIS_SIGNAL_tvalid && (cnt_p0 == last_cnt);
        sum_x     = blk_start ? smp_x : acc_x_p0 + smp_x;
        sum_y     = blk_start ? smp_y : acc_y_p0 + smp_y;
        res_x     = mode_cur ? sat_sum(sum_x) : avg_round(sum_x, k_cur);
        res_y     = mode_cur ? sat_sum(sum_y) : avg_round(sum_y, k_cur);
    end

    // Stage p0: beat counting and accumulation
    always_ff @(posedge adc_clk) begin
        if (!adc_resetn) begin
            cnt_p0      <= '0;
            k_act_p0    <= '0;
            mode_act_p0 <= 1'b0;
            acc_x_p0    <= '0;
            acc_y_p0    <= '0;
        end else if (S_AXIS_SIGNAL_tvalid) begin
            if (blk_start) begin
                k_act_p0    <= k_cur;
                mode_act_p0 <= mode_cur;
            end
            cnt_p0   <= blk_last ? '0 : cnt_p0 + 1'b1;
            acc_x_p0 <= sum_x;
            acc_y_p0 <= sum_y;
        end
    end

    // Stage p1: result registers and S01 handshake
    always_ff @(posedge adc_clk) begin
        if (!adc_resetn) begin
            res_x_p1    <= '0;
            res_y_p1    <= '0;
            vld_p1      <= 1'b0;
            s01_data_p1 <= '0;
            s01_vld_p1  <= 1'b0;
            ovr_p1      <= 1'b0;
        end else begin
            vld_p1 <= blk_last;
            if (blk_last) begin
                res_x_p1    <= res_x;
                res_y_p1    <= res_y;
                s01_data_p1 <= {res_y, res_x};
                s01_vld_p1  <= 1'b1;
                // A pending word taken in this same cycle is accepted, so it is not an overrun.
                if (s01_vld_p1 && !M_AXIS_S01_tready) ovr_p1 <= 1'b1;
            end else if (s01_vld_p1 && M_AXIS_S01_tready) begin
                s01_vld_p1 <= 1'b0;
            end
        end
    end

    assign M_AXIS_S0_tdata   = res_x_p1;
    assign M_AXIS_S1_tdata   = res_y_p1;
    assign M_AXIS_S0_tvalid  = vld_p1;
    assign M_AXIS_S1_tvalid  = vld_p1;
    assign M_AXIS_S01_tdata  = s01_data_p1;
    assign M_AXIS_S01_tvalid = s01_vld_p1;
    assign overrun           = ovr_p1;

endmodule

// File: tb/tb_axis_boxcar_decimator.sv
// Testbench for axis_boxcar_decimator: directed scenarios followed by random traffic,
// compared each cycle against a block-level reference model.
module tb_axis_boxcar_decimator;

    logic        adc_clk = 1'b0;
    logic        adc_resetn = 1'b0;
    logic [3:0]  dec_shift = 4'd0;
    logic        dec_mode = 1'b0;
    logic [31:0] s_tdata = '0;
    logic        s_tvalid = 1'b0;
    logic [15:0] s0_tdata, s1_tdata;
    logic        s0_tvalid, s1_tvalid;
    logic [31:0] s01_tdata;
    logic        s01_tvalid;
    logic        s01_tready = 1'b1;
    logic        overrun;

    axis_boxcar_decimator dut (
        .adc_clk              (adc_clk),
        .adc_resetn           (adc_resetn),
        .dec_shift            (dec_shift),
        .dec_mode             (dec_mode),
        .S_AXIS_SIGNAL_tdata  (s_tdata),
        .S_AXIS_SIGNAL_tvalid (s_tvalid),
        .M_AXIS_S0_tdata      (s0_tdata),
        .M_AXIS_S0_tvalid     (s0_tvalid),
        .M_AXIS_S1_tdata      (s1_tdata),
        .M_AXIS_S1_tvalid     (s1_tvalid),
        .M_AXIS_S01_tdata     (s01_tdata),
        .M_AXIS_S01_tvalid    (s01_tvalid),
        .M_AXIS_S01_tready    (s01_tready),
        .overrun              (overrun)
    );

    always #5 adc_clk = ~adc_clk;

    int checks = 0;
    int errors = 0;

    // Reference model state: the beats collected for the current block, plus the expected outputs.
    int          qx[$];
    int          qy[$];
    int          mk = 0;
    bit          mm = 1'b0;
    logic [15:0] e_s0d = '0, e_s1d = '0;
    bit          e_vld = 1'b0;
    logic [31:0] e_s01d = '0;
    bit          e_s01v = 1'b0;
    bit          e_ovr = 1'b0;
    int          d_hs = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int sext14(input logic [13:0] v);
        int r;
        r = int'(v);
        if (v[13]) r = r - 16384;
        return r;
    endfunction

    function automatic logic [31:0] pk(input int x, input int y);
        return {2'b00, y[13:0], 2'b00, x[13:0]};
    endfunction

    // Block result from the beats themselves: floor((sum + N/2) / N), or the sum clamped to 16 bits.
    function automatic logic [15:0] blk_result(input int q[$], input int k, input bit m);
        int sum, n, num, res;
        sum = 0;
        foreach (q[i]) sum += q[i];
        n = 1 << k;
        if (m) begin
            res = (sum > 32767) ? 32767 : (sum < -32768) ? -32768 : sum;
        end else begin
            num = sum + n / 2;
            res = num / n;
            if ((num % n) != 0 && num < 0) res = res - 1;
        end
        return res[15:0];
    endfunction

    task automatic model_edge();
        bit new_res;
        new_res = 1'b0;
        if (!adc_resetn) begin
            qx.delete(); qy.delete();
            mk = 0; mm = 1'b0;
            e_s0d = '0; e_s1d = '0; e_vld = 1'b0;
            e_s01d = '0; e_s01v = 1'b0; e_ovr = 1'b0;
            return;
        end
        if (s_tvalid) begin
            if (qx.size() == 0) begin
                mk = (int'(dec_shift) > 8) ? 8 : int'(dec_shift);
                mm = dec_mode;
            end
            qx.push_back(sext14(s_tdata[13:0]));
            qy.push_back(sext14(s_tdata[29:16]));
            if (qx.size() == (1 << mk)) begin
                e_s0d = blk_result(qx, mk, mm);
                e_s1d = blk_result(qy, mk, mm);
                qx.delete(); qy.delete();
                new_res = 1'b1;
            end
        end
        e_vld = new_res;
        if (new_res) begin
            if (e_s01v && !s01_tready) e_ovr = 1'b1;
            e_s01d = {e_s1d, e_s0d};
            e_s01v = 1'b1;
        end else if (e_s01v && s01_tready) begin
            e_s01v = 1'b0;
        end
    endtask

    task automatic tick(input logic v, input logic [31:0] d);
        s_tvalid = v;
        s_tdata  = d;
        if (adc_resetn && s01_tvalid && s01_tready) d_hs++;
        model_edge();
        @(posedge adc_clk);
        #1;
        chk("s0_tvalid",  s0_tvalid,  e_vld);
        chk("s1_tvalid",  s1_tvalid,  e_vld);
        chk("s0_tdata",   s0_tdata,   e_s0d);
        chk("s1_tdata",   s1_tdata,   e_s1d);
        chk("s01_tvalid", s01_tvalid, e_s01v);
        chk("s01_tdata",  s01_tdata,  e_s01d);
        chk("overrun",    overrun,    e_ovr);
    endtask

    initial begin
        int base;
        logic [31:0] rd;

        // Reset
        adc_resetn = 1'b0;
        tick(1'b0, '0);
        tick(1'b0, '0);
        adc_resetn = 1'b1;

        // k=2 average, constant inputs
        dec_shift = 4'd2; dec_mode = 1'b0; s01_tready = 1'b1;
        for (int i = 0; i < 12; i++) tick(1'b1, pk(100, -100));
        chk("t1_pulse", s0_tvalid, 1'b1);
        chk("t1_s0", s0_tdata, 32'h0064);
        chk("t1_s1", s1_tdata, 32'hff9c);

        // k=1 average with gaps
        dec_shift = 4'd1;
        tick(1'b1, pk(1, 0));
        for (int i = 0; i < 3; i++) tick(1'b0, pk(77, 77));
        tick(1'b1, pk(2, 0));
        chk("t2_first", s0_tdata, 32'h0002);
        tick(1'b1, pk(-1, 0));
        tick(1'b0, '0);
        tick(1'b1, pk(-2, 0));
        chk("t2_second", s0_tdata, 32'hffff);

        // k=4 saturated sum
        dec_shift = 4'd4; dec_mode = 1'b1;
        for (int i = 0; i < 16; i++) tick(1'b1, pk(8191, -8192));
        chk("t3_s0_sat", s0_tdata, 32'h7fff);
        chk("t3_s1_sat", s1_tdata, 32'h8000);

        // k=0 average, every beat is a result
        dec_shift = 4'd0; dec_mode = 1'b0;
        for (int i = 0; i < 3; i++) tick(1'b1, 32'hC000_2000);
        chk("t4_s0", s0_tdata, 32'he000);
        chk("t4_s01", s01_tdata, 32'h0000_e000);
        chk("t4_ovr", overrun, 1'b0);

        // Backpressure on S01
        dec_shift = 4'd1; s01_tready = 1'b0;
        for (int i = 0; i < 4; i++) tick(1'b1, pk(10 + i, -i));
        chk("t5_ovr", overrun, 1'b1);
        chk("t5_hold", s01_tdata[15:0], 32'h000d);
        s01_tready = 1'b1;
        base = d_hs;
        for (int i = 0; i < 3; i++) tick(1'b0, '0);
        chk("t5_handshakes", d_hs - base, 1);
        chk("t5_vld_drop", s01_tvalid, 1'b0);

        // Config change mid-block, then reset mid-block
        dec_shift = 4'd2;
        tick(1'b1, pk(4, 4));
        tick(1'b1, pk(4, 4));
        dec_shift = 4'd3;
        tick(1'b1, pk(8, 8));
        tick(1'b1, pk(8, 8));
        chk("t6_n4", s0_tdata, 32'h0006);
        for (int i = 0; i < 7; i++) tick(1'b1, pk(3, 3));
        chk("t6_no_early", s0_tvalid, 1'b0);
        tick(1'b1, pk(3, 3));
        chk("t6_n8", s0_tdata, 32'h0003);
        for (int i = 0; i < 3; i++) tick(1'b1, pk(5, 5));
        adc_resetn = 1'b0;
        tick(1'b1, pk(5, 5));
        chk("t6_rst_s0", s0_tdata, 32'h0);
        chk("t6_rst_ovr", overrun, 1'b0);
        adc_resetn = 1'b1;
        for (int i = 0; i < 8; i++) tick(1'b1, pk(7, -7));
        chk("t6_fresh", s0_tdata, 32'h0007);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 39) == 0)
                dec_shift = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15))
                                                         : 4'($urandom_range(0, 3));
            if ($urandom_range(0, 39) == 0) dec_mode = 1'($urandom_range(0, 1));
            s01_tready = ($urandom_range(0, 3) != 0);
            adc_resetn = ($urandom_range(0, 599) != 0);
            rd = $urandom;
            case ($urandom_range(0, 3))
                0: rd = {rd[31:30], 14'h1fff, rd[15:14], 14'h1fff};
                1: rd = {rd[31:30], 14'h2000, rd[15:14], 14'h2000};
                default: ;
            endcase
            tick(($urandom_range(0, 3) != 0), rd);
        end
        adc_resetn = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
